// File: rtl/filter_test_scheduler.sv
// filter_test_scheduler: steps the generator through four overlay/rate configurations
// with a delay sweep and reports the peak filter output per step. Optional macro: FILTER_SCHED_LOOP_EN.
module filter_test_scheduler #(
    parameter int DELAY_W = 8,
    parameter int DATA_W  = 16,
    parameter int DWELL_W = 16,
    parameter int SETTLE  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [DWELL_W-1:0] dwell_cycles,
    input  logic [DELAY_W-1:0] delay_start,
    input  logic [DELAY_W-1:0] delay_step,
    input  logic [DATA_W-1:0]  filter_data,
    output logic               test_overlay,
    output logic               test_rate,
    output logic [DELAY_W-1:0] test_delay,
    output logic [1:0]         step_idx,
    output logic               busy,
    output logic               peak_valid,
    output logic [DATA_W-1:0]  peak_value,
    output logic               done
);
    localparam int SET_W = $clog2(SETTLE + 1);
    localparam int CNT_W = (DWELL_W > SET_W) ? DWELL_W : SET_W;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SETTLE,
        S_MEASURE,
        S_REPORT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         step_q, step_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0]  peak_q, peak_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DELAY_W-1:0] dstep_q, dstep_d;
    logic               ov_q, ov_d;
    logic               rate_q, rate_d;
    logic [DELAY_W-1:0] delay_q, delay_d;
    logic               last_step;

`ifdef FILTER_SCHED_LOOP_EN
    assign last_step = 1'b0;
`else
    assign last_step = (step_q == 2'd3);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        acc_d   = acc_q;
        peak_d  = peak_q;
        dwell_d = dwell_q;
        dstep_d = dstep_q;
        ov_d    = ov_q;
        rate_d  = rate_q;
        delay_d = delay_q;

        // Stimulus is loaded on the edge entering SETUP so it is valid during SETUP itself.
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    dwell_d = (dwell_cycles == '0) ? DWELL_W'(1) : dwell_cycles;
                    dstep_d = delay_step;
                    step_d  = '0;
                    ov_d    = 1'b0;
                    rate_d  = 1'b0;
                    delay_d = delay_start;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                acc_d   = '0;
                cnt_d   = '0;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_MEASURE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_MEASURE: begin
                if (filter_data > acc_q) begin
                    acc_d = filter_data;
                end
                if (cnt_q == CNT_W'(dwell_q - DWELL_W'(1))) begin
                    peak_d  = acc_d;
                    cnt_d   = '0;
                    state_d = S_REPORT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_REPORT: begin
                if (last_step) begin
                    step_d  = '0;
                    ov_d    = 1'b0;
                    rate_d  = 1'b0;
                    delay_d = '0;
                    state_d = S_DONE;
                end else begin
                    step_d  = step_q + 2'd1;
                    ov_d    = step_d[1];
                    rate_d  = step_d[0];
                    delay_d = delay_q + dstep_q;
                    state_d = S_SETUP;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            step_d  = '0;
            cnt_d   = '0;
            ov_d    = 1'b0;
            rate_d  = 1'b0;
            delay_d = '0;
            peak_d  = peak_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            step_q  <= '0;
            acc_q   <= '0;
            peak_q  <= '0;
            dwell_q <= '0;
            dstep_q <= '0;
            ov_q    <= 1'b0;
            rate_q  <= 1'b0;
            delay_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
            peak_q  <= peak_d;
            dwell_q <= dwell_d;
            dstep_q <= dstep_d;
            ov_q    <= ov_d;
            rate_q  <= rate_d;
            delay_q <= delay_d;
        end
    end

    assign test_overlay = ov_q;
    assign test_rate    = rate_q;
    assign test_delay   = delay_q;
    assign step_idx     = step_q;
    assign busy         = (state_q == S_SETUP) || (state_q == S_SETTLE) ||
                          (state_q == S_MEASURE) || (state_q == S_REPORT);
    assign peak_valid   = (state_q == S_REPORT);
    assign peak_value   = peak_q;
    assign done         = (state_q == S_DONE);

endmodule

// File: tb/tb_filter_test_scheduler.sv
// Self-checking bench for filter_test_scheduler: per-cycle expectations are derived
// from the step schedule arithmetic (step period, phase offset within the step).
module tb_filter_test_scheduler;
    localparam int DELAY_W = 8;
    localparam int DATA_W  = 16;
    localparam int DWELL_W = 16;
    localparam int SETTLE  = 16;
`ifdef FILTER_SCHED_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               abort;
    logic [DWELL_W-1:0] dwell_cycles;
    logic [DELAY_W-1:0] delay_start;
    logic [DELAY_W-1:0] delay_step;
    logic [DATA_W-1:0]  filter_data;
    logic               test_overlay;
    logic               test_rate;
    logic [DELAY_W-1:0] test_delay;
    logic [1:0]         step_idx;
    logic               busy;
    logic               peak_valid;
    logic [DATA_W-1:0]  peak_value;
    logic               done;

    int errors = 0;
    int checks = 0;
    logic [DATA_W-1:0] exp_peak = '0;

    always #5 clk = ~clk;

    filter_test_scheduler #(
        .DELAY_W(DELAY_W),
        .DATA_W (DATA_W),
        .DWELL_W(DWELL_W),
        .SETTLE (SETTLE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .dwell_cycles(dwell_cycles),
        .delay_start (delay_start),
        .delay_step  (delay_step),
        .filter_data (filter_data),
        .test_overlay(test_overlay),
        .test_rate   (test_rate),
        .test_delay  (test_delay),
        .step_idx    (step_idx),
        .busy        (busy),
        .peak_valid  (peak_valid),
        .peak_value  (peak_value),
        .done        (done)
    );

    // Runs one sequence; cycle n=1 is the SETUP cycle right after the start edge.
    // mode: 0 ramp, 1 random, 2 fixed pattern in MEASURE with 0xFFFF elsewhere.
    task automatic run_seq(input int dw_in, input int dstart, input int dstep,
                           input int mode, input int abort_n_in, input int restart_n);
        int P, dw, N, abort_n, k, off, j;
        logic e_idle, e_done, e_busy, e_ov, e_rate, e_pv, meas;
        logic [1:0]         e_step;
        logic [DELAY_W-1:0] e_delay;
        logic [DATA_W-1:0]  acc, fd;
        logic [DATA_W-1:0]  pat [5];
        pat = '{16'd3, 16'd900, 16'd40, 16'd899, 16'd0};
        dw = (dw_in == 0) ? 1 : dw_in;
        P = 2 + SETTLE + dw;
        abort_n = abort_n_in;
        if (LOOP && abort_n == 0) abort_n = 6 * P;
        N = (abort_n > 0) ? abort_n + 3 : 4 * P + 3;
        acc = '0;
        @(negedge clk);
        start = 1'b1;
        abort = 1'b0;
        dwell_cycles = DWELL_W'(dw_in);
        delay_start  = DELAY_W'(dstart);
        delay_step   = DELAY_W'(dstep);
        for (int n = 1; n <= N; n++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            dwell_cycles = DWELL_W'($urandom);
            delay_start  = DELAY_W'($urandom);
            delay_step   = DELAY_W'($urandom);
            e_idle = (abort_n > 0 && n > abort_n) || (!LOOP && n > 4 * P + 1);
            e_done = !e_idle && !LOOP && (n == 4 * P + 1);
            k = (n - 1) / P;
            off = (n - 1) % P;
            e_busy = 1'b0; e_ov = 1'b0; e_rate = 1'b0; e_pv = 1'b0; meas = 1'b0;
            e_step = '0; e_delay = '0;
            if (!e_idle && !e_done) begin
                e_busy  = 1'b1;
                e_step  = 2'(k % 4);
                e_ov    = ((k / 2) % 2) == 1;
                e_rate  = (k % 2) == 1;
                e_delay = DELAY_W'(dstart + k * dstep);
                e_pv    = (off == P - 1);
                meas    = (off > SETTLE) && (off <= SETTLE + dw);
                if (off == 0) acc = '0;
            end
            if (e_pv) exp_peak = acc;

            checks++; if (busy !== e_busy) begin errors++; $display("FAIL busy n=%0d got %b exp %b", n, busy, e_busy); end
            checks++; if (done !== e_done) begin errors++; $display("FAIL done n=%0d got %b exp %b", n, done, e_done); end
            checks++; if (peak_valid !== e_pv) begin errors++; $display("FAIL peak_valid n=%0d got %b exp %b", n, peak_valid, e_pv); end
            checks++; if (test_overlay !== e_ov) begin errors++; $display("FAIL overlay n=%0d got %b exp %b", n, test_overlay, e_ov); end
            checks++; if (test_rate !== e_rate) begin errors++; $display("FAIL rate n=%0d got %b exp %b", n, test_rate, e_rate); end
            checks++; if (test_delay !== e_delay) begin errors++; $display("FAIL delay n=%0d got %0d exp %0d", n, test_delay, e_delay); end
            checks++; if (step_idx !== e_step) begin errors++; $display("FAIL step_idx n=%0d got %0d exp %0d", n, step_idx, e_step); end
            checks++; if (peak_value !== exp_peak) begin errors++; $display("FAIL peak_value n=%0d got %0d exp %0d", n, peak_value, exp_peak); end

            case (mode)
                0: fd = DATA_W'((n - 1) % 256);
                1: fd = DATA_W'($urandom);
                default: begin
                    fd = 16'hFFFF;
                    if (meas) begin
                        j = off - SETTLE - 1;
                        fd = '0;
                        if (j < 5) fd = pat[j];
                    end
                end
            endcase
            filter_data = fd;
            if (meas && fd > acc) acc = fd;
            if (n == abort_n) abort = 1'b1;
            if (n == restart_n) begin
                start = 1'b1;
                dwell_cycles = DWELL_W'(3);
                delay_start  = DELAY_W'(99);
                delay_step   = DELAY_W'(7);
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; filter_data = '0;
        dwell_cycles = '0; delay_start = '0; delay_step = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        exp_peak = '0;
        checks++;
        if ({busy, done, peak_valid, test_overlay, test_rate, test_delay, step_idx, peak_value} !== '0) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b pv=%b ov=%b rate=%b delay=%0d step=%0d peak=%0d exp all 0",
                     busy, done, peak_valid, test_overlay, test_rate, test_delay, step_idx, peak_value);
        end
    endtask

    task automatic test_basic_pass();
        run_seq(8, 10, 5, 0, 0, 0);
    endtask

    task automatic test_peak_tracking();
        run_seq(5, 1, 1, 2, 0, 0);
        checks++;
        if (peak_value !== 16'd900) begin
            errors++;
            $display("FAIL peak_tracking got %0d exp 900", peak_value);
        end
    endtask

    task automatic test_delay_wrap();
        run_seq(4, 250, 4, 1, 0, 0);
    endtask

    task automatic test_abort();
        // abort during step-1 MEASURE, then a normal full run
        run_seq(8, 20, 3, 1, 1 + (2 + SETTLE + 8) + SETTLE + 3, 0);
        run_seq(8, 10, 5, 1, 0, 0);
    endtask

    task automatic test_start_abort_edges();
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        dwell_cycles = 16'd4; delay_start = 8'd77; delay_step = 8'd1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (busy !== 1'b0 || test_delay !== '0 || peak_valid !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL start_abort_same i=%0d got busy=%b delay=%0d pv=%b done=%b exp idle",
                         i, busy, test_delay, peak_valid, done);
            end
            @(negedge clk);
        end
        // dwell 0 behaves as 1; a start mid-sequence must be ignored
        run_seq(0, 7, 3, 1, 0, 30);
    endtask

`ifdef FILTER_SCHED_LOOP_EN
    task automatic test_loop();
        run_seq(8, 250, 4, 1, 0, 0);
    endtask
`endif

    task automatic test_async_reset();
        @(negedge clk);
        start = 1'b1; dwell_cycles = 16'd8; delay_start = 8'd10; delay_step = 8'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        exp_peak = '0;
        checks++;
        if ({busy, done, peak_valid, test_overlay, test_rate, test_delay, step_idx, peak_value} !== '0) begin
            errors++;
            $display("FAIL async_reset got busy=%b delay=%0d step=%0d peak=%0d exp all 0",
                     busy, test_delay, step_idx, peak_value);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_idle got busy=%b exp 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic_pass();
        test_peak_tracking();
        test_delay_wrap();
        test_abort();
        test_start_abort_edges();
`ifdef FILTER_SCHED_LOOP_EN
        test_loop();
`endif
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/filter_test_scheduler.md
# filter_test_scheduler

Sequences the exponential-signal-generator test stimulus for the filter top level. The block steps through four test configurations (overlay/rate combinations), one per step, with a programmable delay sweep. It drives `test_overlay`, `test_rate` and `test_delay` into the signal generator. It measures the peak of the selected filter output during a dwell window and reports one peak per step, so a filter variant can be characterised without manual stimulus changes.

## Interface
Parameters:
- `DELAY_W`, 8: width of `test_delay`; matches the generator delay width.
- `DATA_W`, 16: width of filter output data.
- `DWELL_W`, 16: width of the dwell-length input.
- `SETTLE`, 16: settle cycles after each configuration change before measuring; must be ≥ 1.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to run a sequence; ignored unless idle.
- `abort`  in  1  stops any sequence and returns to idle.
- `dwell_cycles`  in  DWELL_W  measurement window length per step; latched on accepted `start`.
- `delay_start`  in  DELAY_W  delay for step 0; latched on accepted `start`.
- `delay_step`  in  DELAY_W  delay increment per step; latched on accepted `start`.
- `filter_data`  in  DATA_W  selected filter output, unsigned.
- `test_overlay`  out  1  to generator `overlay`.
- `test_rate`  out  1  to generator `rate`.
- `test_delay`  out  DELAY_W  to generator `delay`.
- `step_idx`  out  2  current step, 0–3.
- `busy`  out  1  high from SETUP through REPORT of the last step.
- `peak_valid`  out  1  one-cycle strobe when a step's peak is ready.
- `peak_value`  out  DATA_W  maximum `filter_data` over the step's dwell window.
- `done`  out  1  one-cycle strobe after the last step's report.

## Operation
- States: IDLE, SETUP, SETTLE, MEASURE, REPORT, DONE.
- **IDLE**
  - On `start` with `abort` low: latch `dwell_cycles`, `delay_start` and `delay_step`.
  - Set step to 0 and go to SETUP.
- **SETUP** (1 cycle)
  - Register the stimulus: `{test_overlay, test_rate}` = step bits `{step[1], step[0]}`, giving (0,0), (0,1), (1,0), (1,1).
  - `test_delay` = `delay_start + step*delay_step`, modulo 2^DELAY_W (wraps silently).
  - Clear the peak accumulator to 0. Go to SETTLE.
- **SETTLE**
  - Count `SETTLE` cycles, then go to MEASURE.
  - `filter_data` is ignored.
- **MEASURE**
  - Each cycle: if `filter_data` > accumulator (unsigned compare), the accumulator takes `filter_data`.
  - Lasts `dwell_cycles` cycles; a value of 0 is treated as 1.
- **REPORT** (1 cycle)
  - `peak_valid` = 1 and `peak_value` = accumulator.
  - `peak_value` holds until the next REPORT or reset.
  - If step = 3, go to DONE; otherwise increment step and go to SETUP.
- **DONE** (1 cycle)
  - `done` = 1; `test_*` return to 0. Go to IDLE.
- **Stimulus hold:** `test_*` hold their SETUP values through SETTLE, MEASURE and REPORT.
- **Abort**
  - `abort` in any non-IDLE state: next state is IDLE and `busy` = 0; `test_*` and `step_idx` go to 0.
  - No `peak_valid` or `done` is issued; `peak_value` keeps its last reported value.
- **Simultaneous events**
  - `start` and `abort` in the same cycle: `abort` wins; the block stays IDLE.
  - `start` while busy: ignored, and the latched parameters are unchanged.

## Timing
- **Reset values:** all outputs 0 (`test_overlay`, `test_rate`, `test_delay`, `step_idx`, `busy`, `peak_valid`, `peak_value`, `done`). State is IDLE and counters are 0.
- **Start:** `start` at edge T gives SETUP at T+1; `busy` and `test_*` become valid at T+1 (registered).
- **Per step:** 1 (SETUP) + SETTLE + max(dwell, 1) + 1 (REPORT) cycles.
- **First report:** `peak_valid` for step 0 at T+2+SETTLE+dwell.
- **Done:** `done` one cycle after the step-3 REPORT; `busy` is low in the DONE cycle.
- **Sampling window:** `filter_data` is sampled on every MEASURE cycle edge only.

## Configuration
- Macro `FILTER_SCHED_LOOP_EN`.
- **Defined:**
  - After the step-3 REPORT the block wraps to step 0 (SETUP) instead of DONE, and runs until `abort`.
  - `done` is never asserted.
  - `test_delay` keeps accumulating: step k+4 uses `delay_start + (k+4)*delay_step` mod 2^DELAY_W, via a free-running step counter whose low two bits are `step_idx`.
- **Undefined:** a single four-step pass followed by DONE, as described above.

## Test plan
- **Basic pass:** reset, then `start` with dwell=8, delay_start=10, delay_step=5, SETTLE=16, `filter_data` ramping 0..255.
  - `test_delay` = 10, 15, 20, 25 across steps 0–3.
  - Overlay/rate = 00, 01, 10, 11.
  - Four `peak_valid` pulses, then `done` once.
- **Peak tracking:** during MEASURE drive `filter_data` = 3, 900, 40, 899, 0.
  - `peak_value` = 900.
  - Values presented during SETTLE (e.g. 0xFFFF) do not affect the peak.
- **Delay wrap:** delay_start=250, delay_step=4, DELAY_W=8.
  - `test_delay` = 250, 254, 2, 6.
- **Abort:** assert `abort` in the step-1 MEASURE.
  - Next cycle: IDLE, `busy`=0, `test_*`=0.
  - No further `peak_valid`; `done` never pulses.
  - A subsequent `start` runs a full sequence normally.
- **Start/abort edge cases:** `start` with `abort` in the same cycle → stays IDLE. Then `start` with dwell=0 → each MEASURE lasts exactly 1 cycle. A second `start` pulse mid-sequence is ignored.
- **Loop mode and reset:** with `FILTER_SCHED_LOOP_EN` defined, run 6 steps.
  - `step_idx` = 0,1,2,3,0,1.
  - `test_delay` continues the arithmetic sequence.
  - Asynchronous `reset` mid-SETTLE clears all outputs immediately.
